// File: rtl/ks_wide_add_sequencer.sv
// Sequences a WORDS x 16-bit add through an external 16-bit adder, one chunk per cycle, carry rippled in a register.
// Latency: WORDS cycles from the accept edge to out_valid.
// Backpressure: the result is held in DONE until out_ready, and no new operand pair is accepted until then.
module ks_wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] in_a,
  input  logic [16*WORDS-1:0] in_b,
  input  logic                in_cin,
  output logic [15:0]         add_a,
  output logic [15:0]         add_b,
  output logic                add_cin,
  input  logic [16:0]         add_sum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] out_sum,
  output logic                out_cout,
  output logic                busy
);

  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IW-1:0]   idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        // The adder is purely combinational, so its sum for this chunk is captured on the same edge.
        add_a   = a_q[16*idx_q +: 16];
        add_b   = b_q[16*idx_q +: 16];
        add_cin = carry_q;
        sum_d[16*idx_q +: 16] = add_sum[15:0];
        carry_d = add_sum[16];
        if (idx_q == IW'(WORDS - 1)) begin
          cout_d  = add_sum[16];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_ks_wide_add_sequencer.sv
// Bench for ks_wide_add_sequencer at WORDS=4 and WORDS=2, with a behavioural 16-bit adder closing the loop.
module tb_ks_wide_add_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid4 = 1'b0, in_ready4, in_cin4 = 1'b0;
  logic [63:0] in_a4 = '0, in_b4 = '0, out_sum4;
  logic [15:0] add_a4, add_b4;
  logic        add_cin4, out_valid4, out_ready4 = 1'b0, out_cout4, busy4;
  logic [16:0] add_sum4;

  logic        in_valid2 = 1'b0, in_ready2, in_cin2 = 1'b0;
  logic [31:0] in_a2 = '0, in_b2 = '0, out_sum2;
  logic [15:0] add_a2, add_b2;
  logic        add_cin2, out_valid2, out_ready2 = 1'b0, out_cout2, busy2;
  logic [16:0] add_sum2;

  assign add_sum4 = {1'b0, add_a4} + {1'b0, add_b4} + {16'd0, add_cin4};
  assign add_sum2 = {1'b0, add_a2} + {1'b0, add_b2} + {16'd0, add_cin2};

  ks_wide_add_sequencer #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4), .add_sum(add_sum4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4),
    .out_cout(out_cout4), .busy(busy4)
  );

  ks_wide_add_sequencer #(.WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .in_cin(in_cin2),
    .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2), .add_sum(add_sum2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_sum(out_sum2),
    .out_cout(out_cout2), .busy(busy2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wide sum computed directly from the operands, truncated to the selected width.
  function automatic logic [64:0] ref_sum(input int sel, input logic [63:0] a, input logic [63:0] b,
                                          input logic c);
    logic [64:0] s;
    if (sel == 4) s = {1'b0, a} + {1'b0, b} + {64'd0, c};
    else          s = {32'd0, {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, c}};
    return s;
  endfunction

  function automatic logic get_irdy(input int sel);
    return (sel == 4) ? in_ready4 : in_ready2;
  endfunction
  function automatic logic get_ovld(input int sel);
    return (sel == 4) ? out_valid4 : out_valid2;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 4) ? busy4 : busy2;
  endfunction
  function automatic logic get_acin(input int sel);
    return (sel == 4) ? add_cin4 : add_cin2;
  endfunction
  function automatic logic [64:0] get_result(input int sel);
    return (sel == 4) ? {out_cout4, out_sum4} : {32'd0, out_cout2, out_sum2};
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [63:0] a, input logic [63:0] b,
                          input logic c);
    if (sel == 4) begin
      in_valid4 = v; in_a4 = a; in_b4 = b; in_cin4 = c;
    end else begin
      in_valid2 = v; in_a2 = a[31:0]; in_b2 = b[31:0]; in_cin2 = c;
    end
  endtask

  task automatic set_ordy(input int sel, input logic r);
    if (sel == 4) out_ready4 = r;
    else          out_ready2 = r;
  endtask

  // Presents one operand pair, waits for out_valid, and reports result, latency and carry-in history.
  task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b, input logic c,
                        input bit scramble, output logic [64:0] got, output int lat,
                        output bit cin_all1);
    check("in_ready_before_accept", {64'd0, get_irdy(sel)}, 65'd1);
    drive_in(sel, 1'b1, a, b, c);
    step();
    drive_in(sel, 1'b0, '0, '0, 1'b0);
    lat = 0;
    cin_all1 = 1'b1;
    while (!get_ovld(sel) && lat < 40) begin
      if (get_busy(sel) && !get_acin(sel)) cin_all1 = 1'b0;
      if (scramble) drive_in(sel, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      step();
      lat++;
    end
    if (lat >= 40) check("out_valid_timeout", 65'(lat), 65'(sel));
    drive_in(sel, 1'b0, '0, '0, 1'b0);
    got = get_result(sel);
  endtask

  task automatic release_result(input int sel);
    set_ordy(sel, 1'b1);
    step();
    set_ordy(sel, 1'b0);
    check("out_valid_after_hs", {64'd0, get_ovld(sel)}, 65'd0);
    check("in_ready_after_hs", {64'd0, get_irdy(sel)}, 65'd1);
  endtask

  initial begin
    logic [64:0] got, held;
    logic [63:0] ra, rb;
    logic        rc;
    int          lat;
    bit          cin1;

    repeat (3) step();
    check("rst_in_ready", {64'd0, in_ready4}, 65'd1);
    check("rst_out_valid", {64'd0, out_valid4}, 65'd0);
    check("rst_busy", {64'd0, busy4}, 65'd0);
    check("rst_add_a", {49'd0, add_a4}, 65'd0);
    check("rst_result", {out_cout4, out_sum4}, 65'd0);
    rst = 1'b0;
    step();

    run_op(4, 64'h1, 64'h2, 1'b0, 1'b0, got, lat, cin1);
    check("small_sum", got, 65'h3);
    check("small_latency", 65'(lat), 65'd4);
    release_result(4);

    run_op(4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, got, lat, cin1);
    check("ripple_sum", got, {1'b1, 64'h0});
    check("ripple_add_cin", {64'd0, cin1}, 65'd1);
    release_result(4);

    run_op(4, 64'h8000_FFFF_0000_1234, 64'h8000_0001_FFFF_0001, 1'b0, 1'b1, got, lat, cin1);
    check("mixed_sum", got, {1'b1, 64'h0001_0000_FFFF_1235});

    // Hold the result under backpressure while a competing operand pair is offered.
    held = {1'b1, 64'h0001_0000_FFFF_1235};
    drive_in(4, 1'b1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_sum_stable", {out_cout4, out_sum4}, held);
      check("bp_in_ready", {64'd0, in_ready4}, 65'd0);
      check("bp_out_valid", {64'd0, out_valid4}, 65'd1);
    end
    drive_in(4, 1'b0, '0, '0, 1'b0);
    release_result(4);
    check("bp_no_overlap_busy", {64'd0, busy4}, 65'd0);

    // Abort partway through RUN.
    drive_in(4, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    step();
    drive_in(4, 1'b0, '0, '0, 1'b0);
    step();
    step();
    check("pre_abort_busy", {64'd0, busy4}, 65'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", {64'd0, in_ready4}, 65'd1);
    check("abort_out_valid", {64'd0, out_valid4}, 65'd0);
    check("abort_add_a", {49'd0, add_a4}, 65'd0);
    check("abort_busy", {64'd0, busy4}, 65'd0);
    check("abort_result", {out_cout4, out_sum4}, 65'd0);
    run_op(4, 64'hDEAD_BEEF_CAFE_F00D, 64'h2152_4110_3501_0FF3, 1'b1, 1'b0, got, lat, cin1);
    check("post_abort_sum", got, ref_sum(4, 64'hDEAD_BEEF_CAFE_F00D, 64'h2152_4110_3501_0FF3, 1'b1));
    release_result(4);

    for (int sel = 2; sel <= 4; sel += 2) begin
      for (int n = 0; n < 1000; n++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        rc = 1'($urandom);
        if ((n % 16) == 0) ra = '1;
        if ((n % 16) == 1) rb = '1;
        run_op(sel, ra, rb, rc, 1'b1, got, lat, cin1);
        check("rand_sum", got, ref_sum(sel, ra, rb, rc));
        check("rand_latency", 65'(lat), 65'(sel));
        release_result(sel);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
